cp2_wb_commit_unit: RTL and testbench
=====================================

Name: cp2_wb_commit_unit

Overview:
- Parametrised write-back/commit stage for the CP2 task coprocessor, between decode and the task/timer register files.
- Captures one decoded CP2 operation per handshake and drives registered write-back controls and data.
- Time-stamped (ts) operations may arrive before cp2_tds. The block holds them up to TDS_TIMEOUT cycles waiting for tds, then commits or drops them.
- Drops are reported with an error pulse and a saturating counter.

Parameters:
DATA_W, 32, width of cp2_tdata / writeBack_data
TASK_ADDR_W, 6, width of task_sel
NUM_ADDR_W, 4, width of ttr_w_number
TDS_TIMEOUT, 8, max cycles (>=1) a ts operation waits for tds
ERR_CNT_W, 8, width of drop counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decode operation valid
in_ready  out  1  block can accept (combinational from state)
flush  in  1  abandon pending operation
decode_ts  in  1  operation needs tds qualification
cp2_tds  in  1  time-data strobe
cp2_tdata  in  DATA_W  time data
decode_task_sel  in  TASK_ADDR_W  task index
decode_task_aord_op  in  2  add/delete op
decode_g_time_write_sel / decode_ttr_w_sel / decode_task_new_status / decode_task_trigger_op  in  1 each  selectors/values
decode_ttr_w_number  in  NUM_ADDR_W  TTR entry
decode_g_time_write_en / decode_ttr_wea / decode_chcy_ena / decode_chph_ena  in  1 each  gated enables (need ts&&tds)
decode_chdeadline_ena / decode_task_chs_ena / decode_task_trigger_op_ena  in  1 each  ungated enables
Outputs, same names without decode_ prefix, same widths, registered
writeBack_data  out  DATA_W  registered data
wb_valid  out  1  one-cycle commit pulse
tds_timeout_err  out  1  one-cycle drop pulse
drop_count  out  ERR_CNT_W  saturating drop counter

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, state IDLE, wait counter 0, capture registers 0.
- Handshake: accept when in_valid && in_ready. in_ready=1 only in IDLE with flush=0.
- States: IDLE, WAIT_TDS.
- IDLE, accept, decode_ts=0: commit next edge. Gated enables forced 0; ungated enables, selectors and data pass through.
- IDLE, accept, decode_ts=1, cp2_tds=1: commit next edge with all enables as decoded. Latency 1 cycle.
- IDLE, accept, decode_ts=1, cp2_tds=0: capture all decode fields; go to WAIT_TDS; counter=0.
- WAIT_TDS, flush=1: return to IDLE; no commit, no error, counter not incremented. Flush has priority over tds in the same cycle.
- WAIT_TDS, cp2_tds=1: commit from captured fields; writeBack_data=cp2_tdata of that cycle; all enables as captured; go to IDLE.
- WAIT_TDS, cp2_tds=0, counter==TDS_TIMEOUT-1: drop. Pulse tds_timeout_err; drop_count+=1, saturating at all-ones; no wb_valid; go to IDLE. Otherwise counter+=1.
- tds arriving on the timeout cycle commits; it is not a drop.
- Commit cycle: wb_valid=1; all *_ena, *_wea and g_time_write_en registered as above.
- Non-commit cycles: wb_valid and every enable output are 0. Selectors, numbers and writeBack_data hold their last committed value.
- Flush in IDLE has no effect besides in_ready=0 that cycle.
- rst in WAIT_TDS discards the pending operation; no error pulse.
- Gated-enable rule is identical on both commit paths: gated enables reach the outputs only if ts && tds.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, in_ready=1 after release, drop_count=0.
- Untimed op: in_valid=1, ts=0, g_time_write_en=1, chdeadline_ena=1, tdata=0x1234 -> next cycle wb_valid=1, g_time_write_en=0, chdeadline_ena=1, writeBack_data=0x1234.
- Same-cycle tds: ts=1, tds=1, chph_ena=1, ttr_w_number=5, task_sel=3 -> next cycle chph_ena=1, ttr_w_number=5, task_sel=3, wb_valid=1, in_ready=1.
- Deferred tds: ts=1, tds=0, then tds=1 three cycles later with tdata=0xABCD -> in_ready=0 while waiting; wb_valid one cycle after the tds cycle; writeBack_data=0xABCD; decoded enables applied.
- Timeout: TDS_TIMEOUT=8, ts=1, tds held 0 -> tds_timeout_err pulses exactly once, 8 cycles after accept; no wb_valid; drop_count=1. Repeat 300 drops with ERR_CNT_W=8 -> drop_count saturates at 255.
- Flush vs tds: in WAIT_TDS assert flush=1 and tds=1 together -> no wb_valid, no error, in_ready=1 next cycle; new op accepted normally.

Source files
------------

// File: rtl/cp2_wb_commit_unit.sv
// CP2 write-back/commit stage: registers one decoded operation per handshake and
// holds time-stamped operations until cp2_tds arrives, committing or dropping them.
module cp2_wb_commit_unit #(
   parameter int DATA_W      = 32,
   parameter int TASK_ADDR_W = 6,
   parameter int NUM_ADDR_W  = 4,
   parameter int TDS_TIMEOUT = 8,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   flush,
   input  logic                   decode_ts,
   input  logic                   cp2_tds,
   input  logic [DATA_W-1:0]      cp2_tdata,
   input  logic [TASK_ADDR_W-1:0] decode_task_sel,
   input  logic [1:0]             decode_task_aord_op,
   input  logic                   decode_g_time_write_sel,
   input  logic                   decode_ttr_w_sel,
   input  logic                   decode_task_new_status,
   input  logic                   decode_task_trigger_op,
   input  logic [NUM_ADDR_W-1:0]  decode_ttr_w_number,
   input  logic                   decode_g_time_write_en,
   input  logic                   decode_ttr_wea,
   input  logic                   decode_chcy_ena,
   input  logic                   decode_chph_ena,
   input  logic                   decode_chdeadline_ena,
   input  logic                   decode_task_chs_ena,
   input  logic                   decode_task_trigger_op_ena,
   output logic [TASK_ADDR_W-1:0] task_sel,
   output logic [1:0]             task_aord_op,
   output logic                   g_time_write_sel,
   output logic                   ttr_w_sel,
   output logic                   task_new_status,
   output logic                   task_trigger_op,
   output logic [NUM_ADDR_W-1:0]  ttr_w_number,
   output logic                   g_time_write_en,
   output logic                   ttr_wea,
   output logic                   chcy_ena,
   output logic                   chph_ena,
   output logic                   chdeadline_ena,
   output logic                   task_chs_ena,
   output logic                   task_trigger_op_ena,
   output logic [DATA_W-1:0]      writeBack_data,
   output logic                   wb_valid,
   output logic                   tds_timeout_err,
   output logic [ERR_CNT_W-1:0]   drop_count
);

   localparam int CNT_W = (TDS_TIMEOUT > 1) ? $clog2(TDS_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TDS_TIMEOUT - 1);

   typedef struct packed {
      logic [TASK_ADDR_W-1:0] task_sel;
      logic [1:0]             task_aord_op;
      logic                   g_time_write_sel;
      logic                   ttr_w_sel;
      logic                   task_new_status;
      logic                   task_trigger_op;
      logic [NUM_ADDR_W-1:0]  ttr_w_number;
      logic                   g_time_write_en;
      logic                   ttr_wea;
      logic                   chcy_ena;
      logic                   chph_ena;
      logic                   chdeadline_ena;
      logic                   task_chs_ena;
      logic                   task_trigger_op_ena;
   } op_t;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_TDS = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   op_t              dec_op, cap_q, cap_d;
   op_t              op_p0, out_p1;
   logic             vld_p0, drop_p0;
   logic [DATA_W-1:0] data_p1;
   logic             vld_p1, err_p1;
   logic [ERR_CNT_W-1:0] drop_cnt_q;

   // Gated enables only survive when the operation is time-stamped and tds is present.
   function automatic op_t gate_op(input op_t op, input logic qual);
      op_t r;
      r                 = op;
      r.g_time_write_en = op.g_time_write_en & qual;
      r.ttr_wea         = op.ttr_wea & qual;
      r.chcy_ena        = op.chcy_ena & qual;
      r.chph_ena        = op.chph_ena & qual;
      return r;
   endfunction

   function automatic op_t clear_enables(input op_t op);
      op_t r;
      r                     = gate_op(op, 1'b0);
      r.chdeadline_ena      = 1'b0;
      r.task_chs_ena        = 1'b0;
      r.task_trigger_op_ena = 1'b0;
      return r;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

   assign dec_op = '{
      task_sel:            decode_task_sel,
      task_aord_op:        decode_task_aord_op,
      g_time_write_sel:    decode_g_time_write_sel,
      ttr_w_sel:           decode_ttr_w_sel,
      task_new_status:     decode_task_new_status,
      task_trigger_op:     decode_task_trigger_op,
      ttr_w_number:        decode_ttr_w_number,
      g_time_write_en:     decode_g_time_write_en,
      ttr_wea:             decode_ttr_wea,
      chcy_ena:            decode_chcy_ena,
      chph_ena:            decode_chph_ena,
      chdeadline_ena:      decode_chdeadline_ena,
      task_chs_ena:        decode_task_chs_ena,
      task_trigger_op_ena: decode_task_trigger_op_ena
   };

   assign in_ready = (state_q == IDLE) && !flush;

   // Stage p0: select the operation to commit and advance the tds wait.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      op_p0   = dec_op;
      vld_p0  = 1'b0;
      drop_p0 = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (!decode_ts || cp2_tds) begin
                  vld_p0 = 1'b1;
                  op_p0  = gate_op(dec_op, decode_ts & cp2_tds);
               end else begin
                  cap_d   = dec_op;
                  cnt_d   = '0;
                  state_d = WAIT_TDS;
               end
            end
         end
         WAIT_TDS: begin
            // Flush wins over a simultaneous tds.
            if (flush) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cp2_tds) begin
               vld_p0  = 1'b1;
               op_p0   = cap_q;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               drop_p0 = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
      end
   end

   // Stage p1: registered write-back outputs; selectors and data hold between commits.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_p1     <= '0;
         data_p1    <= '0;
         vld_p1     <= 1'b0;
         err_p1     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         vld_p1 <= vld_p0;
         err_p1 <= drop_p0;
         if (vld_p0) begin
            out_p1  <= op_p0;
            data_p1 <= cp2_tdata;
         end else begin
            out_p1 <= clear_enables(out_p1);
         end
         if (drop_p0) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
         end
      end
   end

   assign task_sel            = out_p1.task_sel;
   assign task_aord_op        = out_p1.task_aord_op;
   assign g_time_write_sel    = out_p1.g_time_write_sel;
   assign ttr_w_sel           = out_p1.ttr_w_sel;
   assign task_new_status     = out_p1.task_new_status;
   assign task_trigger_op     = out_p1.task_trigger_op;
   assign ttr_w_number        = out_p1.ttr_w_number;
   assign g_time_write_en     = out_p1.g_time_write_en;
   assign ttr_wea             = out_p1.ttr_wea;
   assign chcy_ena            = out_p1.chcy_ena;
   assign chph_ena            = out_p1.chph_ena;
   assign chdeadline_ena      = out_p1.chdeadline_ena;
   assign task_chs_ena        = out_p1.task_chs_ena;
   assign task_trigger_op_ena = out_p1.task_trigger_op_ena;
   assign writeBack_data      = data_p1;
   assign wb_valid            = vld_p1;
   assign tds_timeout_err     = err_p1;
   assign drop_count          = drop_cnt_q;

endmodule

// File: tb/tb_cp2_wb_commit_unit.sv
// Bench for cp2_wb_commit_unit: directed scenarios plus random traffic checked
// against a transaction-level model of pending/committed/dropped operations.
module tb_cp2_wb_commit_unit;

   localparam int DATA_W      = 32;
   localparam int TASK_ADDR_W = 6;
   localparam int NUM_ADDR_W  = 4;
   localparam int TDS_TIMEOUT = 8;
   localparam int ERR_CNT_W   = 8;
   localparam int CNT_MAX     = (1 << ERR_CNT_W) - 1;

   typedef struct packed {
      logic [TASK_ADDR_W-1:0] task_sel;
      logic [1:0]             task_aord_op;
      logic                   g_time_write_sel;
      logic                   ttr_w_sel;
      logic                   task_new_status;
      logic                   task_trigger_op;
      logic [NUM_ADDR_W-1:0]  ttr_w_number;
      logic                   g_time_write_en;
      logic                   ttr_wea;
      logic                   chcy_ena;
      logic                   chph_ena;
      logic                   chdeadline_ena;
      logic                   task_chs_ena;
      logic                   task_trigger_op_ena;
   } op_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, in_valid, flush, decode_ts, cp2_tds;
   logic [DATA_W-1:0] cp2_tdata;
   op_t               d;

   logic                   in_ready;
   logic [TASK_ADDR_W-1:0] task_sel;
   logic [1:0]             task_aord_op;
   logic                   g_time_write_sel, ttr_w_sel, task_new_status, task_trigger_op;
   logic [NUM_ADDR_W-1:0]  ttr_w_number;
   logic                   g_time_write_en, ttr_wea, chcy_ena, chph_ena;
   logic                   chdeadline_ena, task_chs_ena, task_trigger_op_ena;
   logic [DATA_W-1:0]      writeBack_data;
   logic                   wb_valid, tds_timeout_err;
   logic [ERR_CNT_W-1:0]   drop_count;
   op_t                    o;

   assign o = {task_sel, task_aord_op, g_time_write_sel, ttr_w_sel, task_new_status,
               task_trigger_op, ttr_w_number, g_time_write_en, ttr_wea, chcy_ena,
               chph_ena, chdeadline_ena, task_chs_ena, task_trigger_op_ena};

   cp2_wb_commit_unit #(
      .DATA_W(DATA_W), .TASK_ADDR_W(TASK_ADDR_W), .NUM_ADDR_W(NUM_ADDR_W),
      .TDS_TIMEOUT(TDS_TIMEOUT), .ERR_CNT_W(ERR_CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .decode_ts(decode_ts), .cp2_tds(cp2_tds), .cp2_tdata(cp2_tdata),
      .decode_task_sel(d.task_sel), .decode_task_aord_op(d.task_aord_op),
      .decode_g_time_write_sel(d.g_time_write_sel), .decode_ttr_w_sel(d.ttr_w_sel),
      .decode_task_new_status(d.task_new_status), .decode_task_trigger_op(d.task_trigger_op),
      .decode_ttr_w_number(d.ttr_w_number), .decode_g_time_write_en(d.g_time_write_en),
      .decode_ttr_wea(d.ttr_wea), .decode_chcy_ena(d.chcy_ena), .decode_chph_ena(d.chph_ena),
      .decode_chdeadline_ena(d.chdeadline_ena), .decode_task_chs_ena(d.task_chs_ena),
      .decode_task_trigger_op_ena(d.task_trigger_op_ena),
      .task_sel(task_sel), .task_aord_op(task_aord_op), .g_time_write_sel(g_time_write_sel),
      .ttr_w_sel(ttr_w_sel), .task_new_status(task_new_status), .task_trigger_op(task_trigger_op),
      .ttr_w_number(ttr_w_number), .g_time_write_en(g_time_write_en), .ttr_wea(ttr_wea),
      .chcy_ena(chcy_ena), .chph_ena(chph_ena), .chdeadline_ena(chdeadline_ena),
      .task_chs_ena(task_chs_ena), .task_trigger_op_ena(task_trigger_op_ena),
      .writeBack_data(writeBack_data), .wb_valid(wb_valid),
      .tds_timeout_err(tds_timeout_err), .drop_count(drop_count)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: at most one operation outstanding, aged in whole cycles.
   bit                pending = 0;
   op_t               pend_op;
   int                age = 0;
   op_t               e = '0;
   logic [DATA_W-1:0] e_data = '0;
   bit                e_wb = 0, e_err = 0;
   int                e_cnt = 0;

   function automatic op_t no_gated(input op_t op);
      op_t r = op;
      r.g_time_write_en = 0; r.ttr_wea = 0; r.chcy_ena = 0; r.chph_ena = 0;
      return r;
   endfunction

   function automatic op_t no_enables(input op_t op);
      op_t r = no_gated(op);
      r.chdeadline_ena = 0; r.task_chs_ena = 0; r.task_trigger_op_ena = 0;
      return r;
   endfunction

   task automatic step();
      bit  commit = 0;
      bit  drop = 0;
      op_t c = '0;
      #1;
      if (!rst) chk("in_ready", 64'(in_ready), 64'(!pending && !flush));
      if (rst) begin
         pending = 0; age = 0; e = '0; e_data = '0; e_wb = 0; e_err = 0; e_cnt = 0;
      end else begin
         if (!pending) begin
            if (in_valid && !flush) begin
               if (!decode_ts)   begin commit = 1; c = no_gated(d); end
               else if (cp2_tds) begin commit = 1; c = d; end
               else              begin pending = 1; pend_op = d; age = 0; end
            end
         end else if (flush) begin
            pending = 0;
         end else if (cp2_tds) begin
            commit = 1; c = pend_op; pending = 0;
         end else begin
            age++;
            if (age >= TDS_TIMEOUT) begin drop = 1; pending = 0; end
         end
         if (commit) begin e = c; e_data = cp2_tdata; end
         else e = no_enables(e);
         e_wb  = commit;
         e_err = drop;
         if (drop && e_cnt < CNT_MAX) e_cnt++;
      end
      @(posedge clk);
      #1;
      chk("wb_valid", 64'(wb_valid), 64'(e_wb));
      chk("tds_timeout_err", 64'(tds_timeout_err), 64'(e_err));
      chk("drop_count", 64'(drop_count), 64'(e_cnt));
      chk("writeBack_data", 64'(writeBack_data), 64'(e_data));
      chk("fields", 64'(o), 64'(e));
   endtask

   task automatic idle_in();
      logic [31:0] r;
      r = $urandom;
      rst = 0; in_valid = 0; flush = 0; decode_ts = 0; cp2_tds = 0;
      cp2_tdata = $urandom;
      d = r[$bits(op_t)-1:0];
   endtask

   int  k;
   bit  seen_wb;
   op_t dd;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_in();
      rst = 1;
      step(); step();
      chk("rst_outputs", 64'({o, writeBack_data, wb_valid, tds_timeout_err, drop_count}), 64'(0));
      idle_in();
      step();
      chk("rst_ready", 64'(in_ready), 64'(1));

      // Untimed op: gated enable suppressed, ungated passes.
      idle_in(); d = '0; in_valid = 1; d.g_time_write_en = 1; d.chdeadline_ena = 1;
      cp2_tdata = 32'h1234;
      step();
      chk("ut_wb", 64'(wb_valid), 64'(1));
      chk("ut_gte", 64'(g_time_write_en), 64'(0));
      chk("ut_cdl", 64'(chdeadline_ena), 64'(1));
      chk("ut_data", 64'(writeBack_data), 64'(32'h1234));

      // Same-cycle tds.
      idle_in(); d = '0; in_valid = 1; decode_ts = 1; cp2_tds = 1;
      d.chph_ena = 1; d.ttr_w_number = 5; d.task_sel = 3;
      step();
      chk("sc_chph", 64'(chph_ena), 64'(1));
      chk("sc_num", 64'(ttr_w_number), 64'(5));
      chk("sc_sel", 64'(task_sel), 64'(3));
      chk("sc_wb", 64'(wb_valid), 64'(1));
      chk("sc_ready", 64'(in_ready), 64'(1));

      // Deferred tds three cycles after accept.
      idle_in(); in_valid = 1; decode_ts = 1; d.chcy_ena = 1; d.ttr_wea = 1; dd = d;
      step();
      for (int i = 0; i < 2; i++) begin
         idle_in(); in_valid = 1;
         step();
         chk("df_ready", 64'(in_ready), 64'(0));
         chk("df_nowb", 64'(wb_valid), 64'(0));
      end
      idle_in(); cp2_tds = 1; cp2_tdata = 32'hABCD;
      step();
      chk("df_wb", 64'(wb_valid), 64'(1));
      chk("df_data", 64'(writeBack_data), 64'(32'hABCD));
      chk("df_fields", 64'(o), 64'(dd));

      // Timeout: error pulse TDS_TIMEOUT cycles after accept, no commit.
      idle_in(); in_valid = 1; decode_ts = 1;
      step();
      k = 0; seen_wb = 0;
      while (k < 20 && !tds_timeout_err) begin
         idle_in(); step(); k++;
         if (wb_valid) seen_wb = 1;
      end
      chk("to_latency", 64'(k), 64'(TDS_TIMEOUT));
      chk("to_nowb", 64'(seen_wb), 64'(0));
      chk("to_count", 64'(drop_count), 64'(1));
      idle_in(); step();
      chk("to_single", 64'(tds_timeout_err), 64'(0));

      // Flush and tds together while waiting.
      idle_in(); in_valid = 1; decode_ts = 1;
      step();
      idle_in(); flush = 1; cp2_tds = 1;
      step();
      chk("fl_nowb", 64'(wb_valid), 64'(0));
      chk("fl_noerr", 64'(tds_timeout_err), 64'(0));
      idle_in(); in_valid = 1;
      step();
      chk("fl_new", 64'(wb_valid), 64'(1));

      // Saturating drop counter.
      for (int n = 0; n < 300; n++) begin
         idle_in(); in_valid = 1; decode_ts = 1;
         step();
         for (int j = 0; j < TDS_TIMEOUT; j++) begin idle_in(); step(); end
      end
      chk("sat_count", 64'(drop_count), 64'(CNT_MAX));

      // Random traffic against the model.
      idle_in(); rst = 1; step();
      for (int n = 0; n < 3000; n++) begin
         idle_in();
         rst       = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         decode_ts = $urandom_range(0, 1);
         cp2_tds   = ($urandom_range(0, 4) == 0);
         flush     = ($urandom_range(0, 11) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
